// File: rtl/pipe_reg_skid.sv
// Pipeline boundary register with a valid/ready handshake and a 2-entry skid buffer.
// Define PIPE_STAT_EN to enable the saturating stall_cnt statistics counter.
module pipe_reg_skid #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 69,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Bit 0 is the main valid, bit 1 the skid valid.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_e;

    state_e state_q, state_d;

    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;

    logic m_valid;
    logic s_valid;
    logic accept;
    logic take;

    assign m_valid = state_q[0];
    assign s_valid = state_q[1];

    assign in_ready  = ~s_valid;
    assign out_valid = m_valid;
    assign out_ctrl  = m_valid ? m_ctrl_q : '0;
    assign out_data  = m_data_q;

    assign accept = in_valid & in_ready;
    assign take   = m_valid & out_ready;

    always_comb begin
        state_d  = state_q;
        m_ctrl_d = m_ctrl_q;
        s_ctrl_d = s_ctrl_q;
        m_data_d = m_data_q;
        s_data_d = s_data_q;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    m_ctrl_d = in_ctrl;
                    m_data_d = in_data;
                    state_d  = ONE;
                end
            end
            ONE: begin
                if (accept && take) begin
                    m_ctrl_d = in_ctrl;
                    m_data_d = in_data;
                end else if (accept) begin
                    s_ctrl_d = in_ctrl;
                    s_data_d = in_data;
                    state_d  = FULL;
                end else if (take) begin
                    m_ctrl_d = '0;
                    state_d  = EMPTY;
                end
            end
            FULL: begin
                if (take) begin
                    m_ctrl_d = s_ctrl_q;
                    m_data_d = s_data_q;
                    s_ctrl_d = '0;
                    state_d  = ONE;
                end
            end
            default: begin
                m_ctrl_d = '0;
                s_ctrl_d = '0;
                state_d  = EMPTY;
            end
        endcase

        // Flush drops everything in flight, including this cycle's input.
        if (flush) begin
            state_d  = EMPTY;
            m_ctrl_d = '0;
            s_ctrl_d = '0;
            m_data_d = m_data_q;
            s_data_d = s_data_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            m_ctrl_q <= '0;
            s_ctrl_q <= '0;
            m_data_q <= '0;
            s_data_q <= '0;
        end else begin
            state_q  <= state_d;
            m_ctrl_q <= m_ctrl_d;
            s_ctrl_q <= s_ctrl_d;
            m_data_q <= m_data_d;
            s_data_q <= s_data_d;
        end
    end

`ifdef PIPE_STAT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed + random bench for pipe_reg_skid: occupancy model plus in-order scoreboard.
// Honours PIPE_STAT_EN for the expected stall_cnt.
module tb_pipe_reg_skid;

    localparam int CTRL_W = 2;
    localparam int DATA_W = 69;
    localparam int CNT_W  = 4;
    localparam int EW     = CTRL_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    pipe_reg_skid #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int occ  = 0;
    logic [CNT_W-1:0] exp_stall = '0;
    logic [EW-1:0] sb[$];
    logic last_acc;

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs at negedge, advance the model.
    task automatic step(input logic v, input logic [CTRL_W-1:0] c,
                        input logic [DATA_W-1:0] d, input logic ordy,
                        input logic fl);
        logic [EW-1:0] e;
        logic tk;
        logic ac;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        chk("in_ready", 96'(in_ready), 96'(occ < 2));
        chk("out_valid", 96'(out_valid), 96'(occ > 0));
        chk("stall_cnt", 96'(stall_cnt), 96'(exp_stall));
        vecs++;
        assert (!(dut.s_valid && !dut.m_valid))
        else begin
            errs++;
            $error("FAIL illegal_state observed s=%0b m=%0b expected not s&!m",
                   dut.s_valid, dut.m_valid);
        end
        if (occ == 0) chk("idle_ctrl", 96'(out_ctrl), 96'(0));
        tk = (occ > 0) && ordy;
        ac = v && (occ < 2) && !fl;
        if (tk) begin
            if (sb.size() == 0) begin
                vecs++;
                errs++;
                $error("FAIL scoreboard_empty observed take expected none");
            end else begin
                e = sb.pop_front();
                chk("out_ctrl", 96'(out_ctrl), 96'(e[EW-1:DATA_W]));
                chk("out_data", 96'(out_data), 96'(e[DATA_W-1:0]));
            end
        end
`ifdef PIPE_STAT_EN
        if ((occ > 0) && !ordy && (exp_stall != {CNT_W{1'b1}}))
            exp_stall = exp_stall + CNT_W'(1);
`endif
        if (fl) begin
            sb.delete();
            occ = 0;
        end else begin
            if (ac) sb.push_back({c, d});
            occ = occ + int'(ac) - int'(tk);
        end
        last_acc = ac;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_out_valid", 96'(out_valid), 96'(0));
        chk("rst_out_ctrl", 96'(out_ctrl), 96'(0));
        chk("rst_out_data", 96'(out_data), 96'(0));
        chk("rst_in_ready", 96'(in_ready), 96'(1));
        chk("rst_stall_cnt", 96'(stall_cnt), 96'(0));
        sb.delete();
        occ = 0;
        exp_stall = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push_hold(input logic [CTRL_W-1:0] c,
                             input logic [DATA_W-1:0] d, input logic ordy);
        int n = 0;
        last_acc = 1'b0;
        while (!last_acc && n < 10) begin
            step(1'b1, c, d, ordy, 1'b0);
            n++;
        end
        if (!last_acc) begin
            vecs++;
            errs++;
            $error("FAIL accept_timeout observed not accepted expected accepted");
        end
    endtask

    initial begin
        logic [95:0] r;
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_ctrl = '0;
        in_data = '0;
        out_ready = 1'b0;
        #1;
        do_reset();

        // Streaming 1..8 with out_ready high.
        for (int i = 1; i <= 8; i++)
            step(1'b1, CTRL_W'(i), DATA_W'(i), 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Back-pressure: A in main, B in skid, C held upstream.
        step(1'b1, 2'b01, DATA_W'('hA), 1'b0, 1'b0);
        step(1'b1, 2'b10, DATA_W'('hB), 1'b0, 1'b0);
        step(1'b1, 2'b11, DATA_W'('hC), 1'b0, 1'b0);
        chk("bp_in_ready", 96'(in_ready), 96'(0));
        chk("bp_main", 96'(out_data), 96'('hA));
        step(1'b1, 2'b11, DATA_W'('hC), 1'b0, 1'b0);
        push_hold(2'b11, DATA_W'('hC), 1'b1);
        for (int i = 0; i < 4; i++)
            step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("bp_drained", 96'(sb.size()), 96'(0));

        // Flush while FULL with ctrl=11 in both entries.
        step(1'b1, 2'b11, DATA_W'('h51), 1'b0, 1'b0);
        step(1'b1, 2'b11, DATA_W'('h52), 1'b0, 1'b0);
        step(1'b1, 2'b11, DATA_W'('h53), 1'b0, 1'b1);
        chk("fl_out_valid", 96'(out_valid), 96'(0));
        chk("fl_out_ctrl", 96'(out_ctrl), 96'(0));
        chk("fl_in_ready", 96'(in_ready), 96'(1));
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Stall counter saturation, flush leaves it, reset clears it.
        do_reset();
        step(1'b1, 2'b01, DATA_W'('h77), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            step(1'b0, '0, '0, 1'b0, 1'b0);
`ifdef PIPE_STAT_EN
        chk("stall_sat", 96'(stall_cnt), 96'(15));
`else
        chk("stall_tied", 96'(stall_cnt), 96'(0));
`endif
        step(1'b0, '0, '0, 1'b0, 1'b1);
`ifdef PIPE_STAT_EN
        chk("stall_after_flush", 96'(stall_cnt), 96'(15));
`endif

        // Reset asynchronously mid-cycle while FULL.
        step(1'b1, 2'b10, DATA_W'('h91), 1'b0, 1'b0);
        step(1'b1, 2'b10, DATA_W'('h92), 1'b0, 1'b0);
        chk("pre_rst_full", 96'(in_ready), 96'(0));
        do_reset();

        // Random traffic with occasional flush.
        for (int i = 0; i < 10000; i++) begin
            r = {$urandom(), $urandom(), $urandom()};
            step(1'($urandom_range(0, 1)), CTRL_W'($urandom()),
                 r[DATA_W-1:0], 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 31) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
